// File: rtl/wb_pwm_multi.sv
// Wishbone-slave PWM generator: N channels share one prescaler and one period counter,
// with shadowed PERIOD/DUTY copied to the active set only at period wrap or while disabled.
// Bus: single-cycle registered ack, 1-cycle read latency. PWM outputs lag the counter by 1 clk.
module wb_pwm_multi #(
  parameter int CHANNELS = 4,
  parameter int RES      = 8,
  parameter int PRESC_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wb_stb_i,
  input  logic                wb_cyc_i,
  input  logic                wb_we_i,
  input  logic [31:0]         wb_adr_i,
  input  logic [3:0]          wb_sel_i,
  input  logic [31:0]         wb_dat_i,
  output logic [31:0]         wb_dat_o,
  output logic                wb_ack_o,
  output logic [CHANNELS-1:0] pwm_out,
  output logic                wrap_o
);

  localparam logic [5:0] IDX_CTRL   = 6'd0;
  localparam logic [5:0] IDX_PRESC  = 6'd1;
  localparam logic [5:0] IDX_PERIOD = 6'd2;
  localparam logic [5:0] IDX_STATUS = 6'd3;
  localparam int         IDX_DUTY0  = 4;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]          ctrl_q,       ctrl_d;        // [0] ena, [1] inv
  logic [PRESC_W-1:0]  presc_q,      presc_d;
  logic [RES-1:0]      period_sh_q,  period_sh_d;
  logic [RES-1:0]      period_act_q, period_act_d;
  logic [RES-1:0]      duty_sh_q  [CHANNELS];
  logic [RES-1:0]      duty_sh_d  [CHANNELS];
  logic [RES-1:0]      duty_act_q [CHANNELS];
  logic [RES-1:0]      duty_act_d [CHANNELS];
  logic [PRESC_W-1:0]  pcnt_q,       pcnt_d;
  logic [RES-1:0]      cnt_q,        cnt_d;
  logic                ack_q,        ack_d;
  logic [31:0]         dat_q,        dat_d;
  logic                wrap_q,       wrap_d;
  logic [CHANNELS-1:0] pwm_q,        pwm_d;

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  logic [5:0] idx;
  logic       bus_req;
  logic       wr_en;
  logic       rd_en;

  assign idx     = wb_adr_i[7:2];
  // A new access is accepted only while no ack is outstanding, so each strobe
  // phase produces exactly one register access and one ack pulse.
  assign bus_req = wb_stb_i & wb_cyc_i & ~ack_q;
  assign wr_en   = bus_req & wb_we_i;
  assign rd_en   = bus_req & ~wb_we_i;

  // Byte selects and the untouched address/data bits carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{wb_sel_i, wb_adr_i[31:8], wb_adr_i[1:0], wb_dat_i};

  // ---------------------------------------------------------------------------
  // Timing core signals
  // ---------------------------------------------------------------------------
  logic ena;
  logic inv;
  logic tick;
  logic wrap_evt;
  logic load;
  logic pend;

  assign ena = ctrl_q[0];
  assign inv = ctrl_q[1];

  // >= rather than == so that shrinking PRESC below a running pcnt still ticks
  // on the next cycle instead of running pcnt all the way round.
  assign tick     = ena & (pcnt_q >= presc_q);
  assign wrap_evt = tick & (cnt_q == period_act_q);
  // Active registers follow the shadows continuously while disabled, and only
  // at the wrap boundary while running, so a period is never cut mid-way.
  assign load     = wrap_evt | ~ena;

  // Status: any shadow register still waiting to be applied.
  always_comb begin
    pend = (period_sh_q != period_act_q);
    for (int i = 0; i < CHANNELS; i++) begin
      if (duty_sh_q[i] != duty_act_q[i]) pend = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Readback mux (zero-extended; unmapped indices read 0)
  // ---------------------------------------------------------------------------
  logic [31:0] rd_dat;

  // Select the addressed register for a read.
  always_comb begin
    rd_dat = '0;
    case (idx)
      IDX_CTRL:   rd_dat[1:0]         = ctrl_q;
      IDX_PRESC:  rd_dat[PRESC_W-1:0] = presc_q;
      IDX_PERIOD: rd_dat[RES-1:0]     = period_sh_q;
      IDX_STATUS: rd_dat[0]           = pend;
      default: begin
        for (int i = 0; i < CHANNELS; i++) begin
          if (idx == 6'(IDX_DUTY0 + i)) rd_dat[RES-1:0] = duty_sh_q[i];
        end
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Register-file writes and shadow-to-active transfer
  // ---------------------------------------------------------------------------
  // Writes only ever touch shadows; a write coinciding with a load is seen by
  // the active set at the following load, so pend stays set meanwhile.
  always_comb begin
    ctrl_d       = ctrl_q;
    presc_d      = presc_q;
    period_sh_d  = period_sh_q;
    period_act_d = load ? period_sh_q : period_act_q;
    for (int i = 0; i < CHANNELS; i++) begin
      duty_sh_d[i]  = duty_sh_q[i];
      duty_act_d[i] = load ? duty_sh_q[i] : duty_act_q[i];
    end
    if (wr_en) begin
      case (idx)
        IDX_CTRL:   ctrl_d      = wb_dat_i[1:0];
        IDX_PRESC:  presc_d     = wb_dat_i[PRESC_W-1:0];
        IDX_PERIOD: period_sh_d = wb_dat_i[RES-1:0];
        default: begin
          for (int i = 0; i < CHANNELS; i++) begin
            if (idx == 6'(IDX_DUTY0 + i)) duty_sh_d[i] = wb_dat_i[RES-1:0];
          end
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Prescaler, period counter, outputs and bus response
  // ---------------------------------------------------------------------------
  // Next state of the counters, the wrap pulse, the PWM comparators and the bus.
  always_comb begin
    pcnt_d = pcnt_q;
    cnt_d  = cnt_q;
    if (!ena) begin
      pcnt_d = '0;
      cnt_d  = '0;
    end else if (tick) begin
      pcnt_d = '0;
      cnt_d  = wrap_evt ? '0 : cnt_q + 1'b1;
    end else begin
      pcnt_d = pcnt_q + 1'b1;
    end

    wrap_d = wrap_evt;

    for (int i = 0; i < CHANNELS; i++) begin
      pwm_d[i] = ena ? ((cnt_q < duty_act_q[i]) ^ inv) : inv;
    end

    ack_d = wb_stb_i & wb_cyc_i & ~ack_q;
    dat_d = rd_en ? rd_dat : dat_q;
  end

  // State register with synchronous reset; reset drops any ack in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q       <= '0;
      presc_q      <= '0;
      period_sh_q  <= '0;
      period_act_q <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        duty_sh_q[i]  <= '0;
        duty_act_q[i] <= '0;
      end
      pcnt_q <= '0;
      cnt_q  <= '0;
      ack_q  <= 1'b0;
      dat_q  <= '0;
      wrap_q <= 1'b0;
      pwm_q  <= '0;
    end else begin
      ctrl_q       <= ctrl_d;
      presc_q      <= presc_d;
      period_sh_q  <= period_sh_d;
      period_act_q <= period_act_d;
      for (int i = 0; i < CHANNELS; i++) begin
        duty_sh_q[i]  <= duty_sh_d[i];
        duty_act_q[i] <= duty_act_d[i];
      end
      pcnt_q <= pcnt_d;
      cnt_q  <= cnt_d;
      ack_q  <= ack_d;
      dat_q  <= dat_d;
      wrap_q <= wrap_d;
      pwm_q  <= pwm_d;
    end
  end

  assign wb_ack_o = wb_stb_i & wb_cyc_i & ack_q;
  assign wb_dat_o = dat_q;
  assign wrap_o   = wrap_q;
  assign pwm_out  = pwm_q;

endmodule

// File: tb/tb_wb_pwm_multi.sv
// Directed bench for wb_pwm_multi (4 channels, 8-bit, 16-bit prescaler).
// Linear stimulus; every expected value is a hand-derived constant.
// Outputs are sampled on the falling edge.
module tb_wb_pwm_multi;

  localparam int CH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          wb_stb_i;
  logic          wb_cyc_i;
  logic          wb_we_i;
  logic [31:0]   wb_adr_i;
  logic [3:0]    wb_sel_i;
  logic [31:0]   wb_dat_i;
  logic [31:0]   wb_dat_o;
  logic          wb_ack_o;
  logic [CH-1:0] pwm_out;
  logic          wrap_o;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  wb_pwm_multi #(.CHANNELS(CH), .RES(8), .PRESC_W(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .wb_stb_i (wb_stb_i),
    .wb_cyc_i (wb_cyc_i),
    .wb_we_i  (wb_we_i),
    .wb_adr_i (wb_adr_i),
    .wb_sel_i (wb_sel_i),
    .wb_dat_i (wb_dat_i),
    .wb_dat_o (wb_dat_o),
    .wb_ack_o (wb_ack_o),
    .pwm_out  (pwm_out),
    .wrap_o   (wrap_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One bus access: strobe held two cycles; ack must be high on the first and
  // low on the second, read data is taken with the ack.
  task automatic bus(input logic we, input int idx, input logic [31:0] wd,
                     output logic [31:0] rd);
    logic a1, a2;
    @(negedge clk);
    wb_stb_i = 1'b1; wb_cyc_i = 1'b1; wb_we_i = we;
    wb_adr_i = 32'(idx) << 2; wb_dat_i = wd; wb_sel_i = 4'hF;
    @(negedge clk);
    a1 = wb_ack_o; rd = wb_dat_o;
    @(negedge clk);
    a2 = wb_ack_o;
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
    check($sformatf("ack_pulse idx%0d", idx), {30'b0, a1, a2}, 32'h2);
  endtask

  task automatic wr(input int idx, input logic [31:0] d);
    logic [31:0] dummy;
    bus(1'b1, idx, d, dummy);
  endtask

  task automatic rd(input int idx, output logic [31:0] v);
    bus(1'b0, idx, 32'h0, v);
  endtask

  // Returns on the falling edge where wrap_o is seen (counter now at 0).
  task automatic wait_wrap(input string tag, output int hi0);
    bit seen;
    seen = 1'b0;
    hi0  = 0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      hi0 += int'(pwm_out[0]);
      if (wrap_o) seen = 1'b1;
    end
    check({tag, " wrap_seen"}, {31'b0, seen}, 32'h1);
  endtask

  task automatic sample(input int n, output int hi0, output int hi1, output int hi2,
                        output int wraps, output int last_wrap);
    hi0 = 0; hi1 = 0; hi2 = 0; wraps = 0; last_wrap = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      hi0   += int'(pwm_out[0]);
      hi1   += int'(pwm_out[1]);
      hi2   += int'(pwm_out[2]);
      wraps += int'(wrap_o);
      last_wrap = int'(wrap_o);
    end
  endtask

  initial begin
    logic [31:0] v;
    logic [19:0] pv, wv;
    int h0, h1, h2, nw, lw, hx;

    rst = 1'b1; wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
    wb_adr_i = '0; wb_sel_i = '0; wb_dat_i = '0;
    repeat (3) @(negedge clk);
    check("reset pwm_out", 32'(pwm_out), 32'h0);
    check("reset wrap_o", {31'b0, wrap_o}, 32'h0);
    check("reset ack", {31'b0, wb_ack_o}, 32'h0);
    check("reset dat_o", wb_dat_o, 32'h0);
    rst = 1'b0;

    // 1) every register reads 0 after reset
    for (int i = 0; i < 8; i++) begin
      rd(i, v);
      check($sformatf("reset read idx%0d", i), v, 32'h0);
    end

    // 2) PRESC=0, PERIOD=9, DUTY0=3, enable; first 20 clocks after enable
    wr(1, 0); wr(2, 9); wr(4, 3); wr(0, 1);
    rd(0, v);
    check("ctrl readback", v, 32'h1);
    // bench samples restart alignment: after rd(0) the window starts 3 clocks later,
    // so re-synchronise on a wrap and capture 20 samples from there.
    wait_wrap("t2 sync", hx);
    for (int s = 0; s < 20; s++) begin
      @(negedge clk);
      pv[s] = pwm_out[0];
      wv[s] = wrap_o;
    end
    // after a wrap: high for cnt 0,1,2 (samples 0-2, 10-12), wrap at samples 9, 19
    check("t2 pwm0 pattern", {12'b0, pv}, 32'h01C07);
    check("t2 wrap pattern", {12'b0, wv}, 32'h80200);

    // 3) DUTY0 3 -> 7 mid-period: old duty until the next wrap, pend meanwhile
    wait_wrap("t3 sync", hx);
    wr(4, 7);
    rd(3, v);
    check("t3 pend set", v, 32'h1);
    rd(4, v);
    check("t3 duty0 shadow readback", v, 32'h7);
    wait_wrap("t3 tail", hx);
    check("t3 tail keeps old duty", 32'(hx), 32'h0);
    sample(10, h0, h1, h2, nw, lw);
    check("t3 new duty highs", 32'(h0), 32'h7);
    check("t3 wraps per period", 32'(nw), 32'h1);
    check("t3 wrap at period end", 32'(lw), 32'h1);
    rd(3, v);
    check("t3 pend cleared", v, 32'h0);

    // 4) DUTY1=0, DUTY2=10 (> PERIOD), inverted
    wr(5, 0); wr(6, 10); wr(0, 3);
    wait_wrap("t4 sync", hx);
    sample(10, h0, h1, h2, nw, lw);
    check("t4 ch1 duty0 inv const1", 32'(h1), 32'd10);
    check("t4 ch2 duty>period inv const0", 32'(h2), 32'd0);
    check("t4 ch0 duty7 inv highs", 32'(h0), 32'd3);

    // 5) PRESC=3 stretches the period to 40 clocks; unmapped indices
    wr(1, 3);
    wr(40, 32'hFFFF_FFFF);
    rd(40, v);
    check("t5 idx40 reads 0", v, 32'h0);
    rd(8, v);
    check("t5 idx8 reads 0", v, 32'h0);
    wait_wrap("t5 sync", hx);
    sample(40, h0, h1, h2, nw, lw);
    check("t5 wraps in 40 clk", 32'(nw), 32'h1);
    check("t5 wrap at clk 40", 32'(lw), 32'h1);
    check("t5 ch0 inv highs", 32'(h0), 32'd12);

    // 6) reset mid-period and mid-bus-cycle
    rd(0, v);
    check("t6 ctrl before reset", v, 32'h3);
    wait_wrap("t6 sync", hx);
    repeat (13) @(negedge clk);
    check("t6 ch1 high before reset", {31'b0, pwm_out[1]}, 32'h1);
    wb_stb_i = 1'b1; wb_cyc_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 32'h0;
    rst = 1'b1;
    @(negedge clk);
    check("t6 ack lost", {31'b0, wb_ack_o}, 32'h0);
    check("t6 pwm_out cleared", 32'(pwm_out), 32'h0);
    check("t6 wrap_o cleared", {31'b0, wrap_o}, 32'h0);
    check("t6 dat_o cleared", wb_dat_o, 32'h0);
    rst = 1'b0; wb_stb_i = 1'b0; wb_cyc_i = 1'b0;
    sample(50, h0, h1, h2, nw, lw);
    check("t6 idle pwm0", 32'(h0), 32'h0);
    check("t6 idle pwm1", 32'(h1), 32'h0);
    check("t6 idle wraps", 32'(nw), 32'h0);
    rd(0, v); check("t6 ctrl reset", v, 32'h0);
    rd(1, v); check("t6 presc reset", v, 32'h0);
    rd(2, v); check("t6 period reset", v, 32'h0);
    rd(4, v); check("t6 duty0 reset", v, 32'h0);
    wr(2, 9); wr(4, 3); wr(0, 1);
    wait_wrap("t6 restart", hx);
    sample(10, h0, h1, h2, nw, lw);
    check("t6 restart highs", 32'(h0), 32'd3);
    check("t6 restart wrap", 32'(lw), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
